rob_commit_unit: RTL and testbench
==================================

// Module: rob_commit_unit
// PURPOSE
//  Reorder buffer with in-order commit. Allocates entries at dispatch and marks
//  them done from execute/memory completions. Retires at most one entry per cycle
//  and emits the commit events that the hazard controller consumes:
//   - register writeback
//   - branch commit (rob_branch_commit: valid_branch, branch_outcome)
//   - jump-register commit (rob_jump_reg_commit: valid_jump_reg, jump_target)
//  Squashes all younger entries when the hazard controller flushes.
// PARAMETERS
//  ROB_DEPTH       16  entry count, power of two (taken from mips_core_pkg)
//  ROB_DEPTH_BITS   4  $clog2(ROB_DEPTH), pointer/tag width
//  DATA_WIDTH      32  result / target width
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   synchronous active-low reset
//  alloc_valid      in   1   dispatch requests an entry this cycle
//  alloc_is_branch  in   1   entry is a conditional branch
//  alloc_is_jr      in   1   entry is a jump-register
//  alloc_is_store   in   1   entry is a store
//  alloc_dest       in   5   dest register; 0 = no writeback
//  alloc_ready      out  1   !full; allocation accepted iff alloc_valid & alloc_ready
//  alloc_tag        out  RDB tail pointer; tag of the entry allocated this cycle
//  cmpl_valid       in   1   completion broadcast
//  cmpl_tag         in   RDB entry being completed
//  cmpl_value       in   32  result value (ALU/load)
//  cmpl_taken       in   1   resolved branch outcome, TAKEN=1
//  cmpl_target      in   32  resolved JR target
//  commit_stall     in   1   hold head if it is a store (rob_st_hc.stall)
//  flush            in   1   squash request from hazard controller
//  wb_valid         out  1   commit writes wb_reg <= wb_data
//  wb_reg           out  5   commit dest register
//  wb_data          out  32  commit value
//  valid_branch     out  1   a branch retires this cycle (single-cycle pulse)
//  branch_outcome   out  1   its resolved outcome
//  valid_jump_reg   out  1   a JR retires this cycle (single-cycle pulse)
//  jump_target      out  32  its resolved target
//  full, empty      out  1   status (rob_status.full)
//  count            out  RDB+1  occupied entries
// BEHAVIOUR
//  Reset: head=tail=count=0, all entry valid/done bits 0, empty=1, full=0,
//   alloc_ready=1, all commit outputs 0.
//  Storage: circular; head = oldest, tail = next free; pointers wrap ROB_DEPTH-1 -> 0.
//   count is incremented/decremented by alloc/commit in the same cycle (net 0 when both).
//  Allocation: on accept, entry[tail] <= {valid=1, done=0, flags, dest}; tail++.
//   full is computed from registered count only; no alloc-during-commit bypass
//   when full.
//  Completion: if entry[cmpl_tag].valid, set done=1 and latch value/taken/target.
//   Completions targeting invalid entries are ignored. A completion to head makes
//   it eligible the NEXT cycle.
//  Commit (combinational from registered head state, no input-to-output path
//   except commit_stall):
//   - commit = entry[head].valid & entry[head].done & !(is_store & commit_stall).
//   - On commit: wb_valid = (dest!=0); valid_branch = is_branch;
//     valid_jump_reg = is_jr; entry[head].valid <= 0; head++.
//   - Exactly one valid_branch pulse per branch, in program order, so the
//     hazard controller's bp_rd_ptr stays aligned.
//  Flush (same cycle as the committing branch/JR): the head commit still retires
//   and its outputs are still driven. Next cycle: every entry valid=0,
//   head=tail=(head+commit), count=0. Alloc and cmpl in the flush cycle are
//   dropped.
//  Reset mid-operation overrides flush, alloc and completion.
// STRUCTURE
//  mips_core_pkg holds ROB_DEPTH, ROB_DEPTH_BITS, the branch_outcome enum
//   (NOT_TAKEN=0, TAKEN=1) and typedef struct rob_entry_t
//   {valid, done, is_branch, is_jr, is_store, dest, value, taken, target}.
//  Single module; entry array is a flat reg array indexed by pointer.
//  No sub-module.
// TESTING
//  1. Alloc 3 ALU ops (dest 1,2,3); complete tags 2,0,1 with 0xA,0xB,0xC
//     -> wb in order r1=0xB, r2=0xC, r3=0xA on consecutive cycles.
//  2. Alloc 16 entries -> full=1, alloc_ready=0; 17th alloc ignored, tail
//     unchanged; commit one -> alloc_ready=1 next cycle; tag wraps 15->0.
//  3. Branch at head completed taken=1 -> valid_branch=1, branch_outcome=1 for
//     exactly one cycle; flush same cycle with 4 younger entries -> next cycle
//     count=0, empty=1, no further commits.
//  4. JR completed with target 0x0040_0100 -> valid_jump_reg=1,
//     jump_target=0x0040_0100, wb_valid=0 if dest=0.
//  5. Store at head done with commit_stall=1 for 3 cycles -> no commit; head
//     retires on the first cycle commit_stall=0.
//  6. Alloc + commit same cycle at count=5 -> count stays 5; rst_n=0 mid-stream
//     -> next cycle empty=1, all outputs 0.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared core types: ROB sizing, branch outcome encoding
// and the reorder-buffer entry record.
package mips_core_pkg;

    localparam int ROB_DEPTH      = 16;
    localparam int ROB_DEPTH_BITS = $clog2(ROB_DEPTH);
    localparam int DATA_WIDTH     = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } branch_outcome_e;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  is_branch;
        logic                  is_jr;
        logic                  is_store;
        logic [4:0]            dest;
        logic [DATA_WIDTH-1:0] value;
        branch_outcome_e       taken;
        logic [DATA_WIDTH-1:0] target;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_unit.sv
// Reorder buffer: allocate at dispatch, complete out of order,
// retire one entry per cycle in program order, squash on flush.
module rob_commit_unit
    import mips_core_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alloc_valid,
    input  logic                      alloc_is_branch,
    input  logic                      alloc_is_jr,
    input  logic                      alloc_is_store,
    input  logic [4:0]                alloc_dest,
    output logic                      alloc_ready,
    output logic [ROB_DEPTH_BITS-1:0] alloc_tag,
    input  logic                      cmpl_valid,
    input  logic [ROB_DEPTH_BITS-1:0] cmpl_tag,
    input  logic [DATA_WIDTH-1:0]     cmpl_value,
    input  logic                      cmpl_taken,
    input  logic [DATA_WIDTH-1:0]     cmpl_target,
    input  logic                      commit_stall,
    input  logic                      flush,
    output logic                      wb_valid,
    output logic [4:0]                wb_reg,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      valid_branch,
    output logic                      branch_outcome,
    output logic                      valid_jump_reg,
    output logic [DATA_WIDTH-1:0]     jump_target,
    output logic                      full,
    output logic                      empty,
    output logic [ROB_DEPTH_BITS:0]   count
);

    localparam int CNT_W = ROB_DEPTH_BITS + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(ROB_DEPTH);

    rob_entry_t                ent_q [ROB_DEPTH];
    logic [ROB_DEPTH_BITS-1:0] head_q, head_d;
    logic [ROB_DEPTH_BITS-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]          count_q, count_d;

    rob_entry_t head_e;
    logic       do_commit;
    logic       do_alloc;
    logic       do_cmpl;

    assign head_e = ent_q[head_q];

    // Status, handshake and retire decision from registered state.
    always_comb begin
        full        = (count_q == DEPTH_CNT);
        empty       = (count_q == '0);
        count       = count_q;
        alloc_ready = !full;
        alloc_tag   = tail_q;
        do_alloc    = alloc_valid & !full;
        do_cmpl     = cmpl_valid & ent_q[cmpl_tag].valid;
        do_commit   = head_e.valid & head_e.done
                    & !(head_e.is_store & commit_stall);
    end

    // Commit event outputs; all zero when nothing retires.
    always_comb begin
        wb_valid       = 1'b0;
        wb_reg         = '0;
        wb_data        = '0;
        valid_branch   = 1'b0;
        branch_outcome = 1'b0;
        valid_jump_reg = 1'b0;
        jump_target    = '0;
        if (do_commit) begin
            wb_valid       = (head_e.dest != 5'd0);
            wb_reg         = head_e.dest;
            wb_data        = head_e.value;
            valid_branch   = head_e.is_branch;
            branch_outcome = head_e.is_branch & (head_e.taken == TAKEN);
            valid_jump_reg = head_e.is_jr;
            jump_target    = head_e.is_jr ? head_e.target : '0;
        end
    end

    // Next pointers/occupancy; flush collapses the ring onto the new head.
    always_comb begin
        head_d  = head_q + ROB_DEPTH_BITS'(do_commit);
        tail_d  = tail_q + ROB_DEPTH_BITS'(do_alloc);
        count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_commit);
        if (flush) begin
            tail_d  = head_d;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry array: complete, retire and allocate; flush drops all.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent_q[i].valid <= 1'b0;
            end
        end else begin
            if (do_cmpl) begin
                ent_q[cmpl_tag].done   <= 1'b1;
                ent_q[cmpl_tag].value  <= cmpl_value;
                ent_q[cmpl_tag].taken  <= branch_outcome_e'(cmpl_taken);
                ent_q[cmpl_tag].target <= cmpl_target;
            end
            if (do_commit) begin
                ent_q[head_q].valid <= 1'b0;
            end
            if (do_alloc) begin
                ent_q[tail_q] <= '{
                    valid:     1'b1,
                    done:      1'b0,
                    is_branch: alloc_is_branch,
                    is_jr:     alloc_is_jr,
                    is_store:  alloc_is_store,
                    dest:      alloc_dest,
                    value:     '0,
                    taken:     NOT_TAKEN,
                    target:    '0
                };
            end
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: directed vector table, hand sequences
// and random traffic against a queue-based reorder model.
module tb_rob_commit_unit;
    import mips_core_pkg::*;

    localparam int RDB = ROB_DEPTH_BITS;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           alloc_valid, alloc_is_branch, alloc_is_jr, alloc_is_store;
    logic [4:0]     alloc_dest;
    logic           alloc_ready;
    logic [RDB-1:0] alloc_tag;
    logic           cmpl_valid;
    logic [RDB-1:0] cmpl_tag;
    logic [31:0]    cmpl_value;
    logic           cmpl_taken;
    logic [31:0]    cmpl_target;
    logic           commit_stall, flush;
    logic           wb_valid;
    logic [4:0]     wb_reg;
    logic [31:0]    wb_data;
    logic           valid_branch, branch_outcome, valid_jump_reg;
    logic [31:0]    jump_target;
    logic           full, empty;
    logic [RDB:0]   count;

    always #5 clk = ~clk;

    rob_commit_unit dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_is_branch(alloc_is_branch),
        .alloc_is_jr(alloc_is_jr), .alloc_is_store(alloc_is_store),
        .alloc_dest(alloc_dest), .alloc_ready(alloc_ready),
        .alloc_tag(alloc_tag), .cmpl_valid(cmpl_valid),
        .cmpl_tag(cmpl_tag), .cmpl_value(cmpl_value),
        .cmpl_taken(cmpl_taken), .cmpl_target(cmpl_target),
        .commit_stall(commit_stall), .flush(flush),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .valid_branch(valid_branch), .branch_outcome(branch_outcome),
        .valid_jump_reg(valid_jump_reg), .jump_target(jump_target),
        .full(full), .empty(empty), .count(count)
    );

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference model: program-order queue of in-flight instructions.
    typedef struct {
        int          tag;
        bit          done;
        bit          br;
        bit          jr;
        bit          st;
        logic [4:0]  dest;
        logic [31:0] val;
        bit          tk;
        logic [31:0] tgt;
    } m_ent_t;

    m_ent_t mq[$];
    int     mh = 0;
    int     mt = 0;

    function automatic m_ent_t m_head();
        m_ent_t h;
        h = '{default: 0};
        if (mq.size() > 0) h = mq[0];
        return h;
    endfunction

    function automatic bit m_commit();
        m_ent_t h;
        h = m_head();
        return (mq.size() > 0) && h.done && !(h.st && commit_stall);
    endfunction

    task automatic model_check();
        m_ent_t h;
        bit c, ewb, ebr, ejr;
        h   = m_head();
        c   = m_commit();
        ewb = c && (h.dest != 0);
        ebr = c && h.br;
        ejr = c && h.jr;
        chk("status",
            {alloc_ready, alloc_tag, full, empty, count},
            {mq.size() < ROB_DEPTH, 4'(mt), mq.size() == ROB_DEPTH,
             mq.size() == 0, 5'(mq.size())});
        chk("commit",
            {wb_valid, ewb ? {wb_reg, wb_data} : 37'd0,
             valid_branch, ebr ? branch_outcome : 1'b0,
             valid_jump_reg, ejr ? jump_target : 32'd0},
            {ewb, ewb ? {h.dest, h.val} : 37'd0,
             ebr, ebr ? h.tk : 1'b0,
             ejr, ejr ? h.tgt : 32'd0});
    endtask

    task automatic model_update();
        bit c, acc;
        m_ent_t e;
        if (!rst_n) begin
            mq.delete();
            mh = 0;
            mt = 0;
            return;
        end
        c = m_commit();
        if (flush) begin
            if (c) mh = (mh + 1) % ROB_DEPTH;
            mq.delete();
            mt = mh;
            return;
        end
        acc = alloc_valid && (mq.size() < ROB_DEPTH);
        if (cmpl_valid) begin
            foreach (mq[i]) begin
                if (mq[i].tag == int'(cmpl_tag)) begin
                    mq[i].done = 1'b1;
                    mq[i].val  = cmpl_value;
                    mq[i].tk   = cmpl_taken;
                    mq[i].tgt  = cmpl_target;
                end
            end
        end
        if (c) begin
            void'(mq.pop_front());
            mh = (mh + 1) % ROB_DEPTH;
        end
        if (acc) begin
            e = '{tag: mt, done: 0, br: alloc_is_branch, jr: alloc_is_jr,
                  st: alloc_is_store, dest: alloc_dest, val: 0, tk: 0, tgt: 0};
            mq.push_back(e);
            mt = (mt + 1) % ROB_DEPTH;
        end
    endtask

    // Called #1 after inputs are driven: model compare, update, next cycle.
    task automatic tick();
        model_check();
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rst_n = 1; alloc_valid = 0; alloc_is_branch = 0; alloc_is_jr = 0;
        alloc_is_store = 0; alloc_dest = 0; cmpl_valid = 0; cmpl_tag = 0;
        cmpl_value = 0; cmpl_taken = 0; cmpl_target = 0;
        commit_stall = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #1;
        tick();
        idle();
    endtask

    typedef struct {
        bit av; bit br; bit jr; bit st; logic [4:0] dest;
        bit cv; logic [3:0] tag; logic [31:0] val; bit tk; logic [31:0] tgt;
        bit stall; bit fl;
        bit wbv; logic [4:0] wbr; logic [31:0] wbd;
        bit vb; bit bo; bit vjr; logic [31:0] jt; logic [4:0] cnt;
    } vec_t;

    vec_t tbl[30];

    initial begin
        localparam logic [31:0] JT = 32'h0040_0100;
        //         av br jr st dst cv tg val    tk tgt st fl wbv wr wbd   vb bo vj jt cnt
        tbl[0]  = '{1,0,0,0,1,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 0};
        tbl[1]  = '{1,0,0,0,2,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 1};
        tbl[2]  = '{1,0,0,0,3,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 2};
        tbl[3]  = '{0,0,0,0,0,  1,2,32'hA, 0,0, 0,0, 0,0,0,     0,0,0,0, 3};
        tbl[4]  = '{0,0,0,0,0,  1,0,32'hB, 0,0, 0,0, 0,0,0,     0,0,0,0, 3};
        tbl[5]  = '{0,0,0,0,0,  1,1,32'hC, 0,0, 0,0, 1,1,32'hB, 0,0,0,0, 3};
        tbl[6]  = '{0,0,0,0,0,  0,0,0,     0,0, 0,0, 1,2,32'hC, 0,0,0,0, 2};
        tbl[7]  = '{0,0,0,0,0,  0,0,0,     0,0, 0,0, 1,3,32'hA, 0,0,0,0, 1};
        tbl[8]  = '{0,0,0,0,0,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 0};
        tbl[9]  = '{1,0,1,0,0,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 0};
        tbl[10] = '{0,0,0,0,0,  1,3,0,     0,JT,0,0, 0,0,0,     0,0,0,0, 1};
        tbl[11] = '{0,0,0,0,0,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,1,JT,1};
        tbl[12] = '{0,0,0,0,0,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 0};
        tbl[13] = '{1,0,0,1,0,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 0};
        tbl[14] = '{0,0,0,0,0,  1,4,0,     0,0, 1,0, 0,0,0,     0,0,0,0, 1};
        tbl[15] = '{0,0,0,0,0,  0,0,0,     0,0, 1,0, 0,0,0,     0,0,0,0, 1};
        tbl[16] = '{0,0,0,0,0,  0,0,0,     0,0, 1,0, 0,0,0,     0,0,0,0, 1};
        tbl[17] = '{0,0,0,0,0,  0,0,0,     0,0, 1,0, 0,0,0,     0,0,0,0, 1};
        tbl[18] = '{0,0,0,0,0,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 1};
        tbl[19] = '{0,0,0,0,0,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 0};
        tbl[20] = '{1,1,0,0,0,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 0};
        tbl[21] = '{1,0,0,0,7,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 1};
        tbl[22] = '{1,0,0,0,8,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 2};
        tbl[23] = '{1,0,0,0,9,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 3};
        tbl[24] = '{1,0,0,0,10, 1,5,0,     1,0, 0,0, 0,0,0,     0,0,0,0, 4};
        tbl[25] = '{1,0,0,0,11, 1,6,32'h9, 0,0, 0,1, 0,0,0,     1,1,0,0, 5};
        tbl[26] = '{0,0,0,0,0,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 0};
        tbl[27] = '{0,0,0,0,0,  1,6,32'h55,0,0, 0,0, 0,0,0,     0,0,0,0, 0};
        tbl[28] = '{1,0,0,0,12, 0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 0};
        tbl[29] = '{0,0,0,0,0,  0,0,0,     0,0, 0,0, 0,0,0,     0,0,0,0, 1};
    end

    initial begin
        idle();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        mq.delete(); mh = 0; mt = 0;
        idle();
        #1;
        chk("rst_status", {alloc_ready, alloc_tag, full, empty, count},
            {1'b1, 4'd0, 1'b0, 1'b1, 5'd0});
        chk("rst_commit", {wb_valid, wb_reg, wb_data, valid_branch,
            branch_outcome, valid_jump_reg, jump_target}, 72'd0);
        tick();

        // Directed table: ordering, JR, store stall, branch + flush.
        for (int v = 0; v < 30; v++) begin
            idle();
            alloc_valid = tbl[v].av; alloc_is_branch = tbl[v].br;
            alloc_is_jr = tbl[v].jr; alloc_is_store = tbl[v].st;
            alloc_dest = tbl[v].dest; cmpl_valid = tbl[v].cv;
            cmpl_tag = tbl[v].tag; cmpl_value = tbl[v].val;
            cmpl_taken = tbl[v].tk; cmpl_target = tbl[v].tgt;
            commit_stall = tbl[v].stall; flush = tbl[v].fl;
            #1;
            chk($sformatf("tbl%0d", v),
                {wb_valid, tbl[v].wbv ? {wb_reg, wb_data} : 37'd0,
                 valid_branch, tbl[v].vb ? branch_outcome : 1'b0,
                 valid_jump_reg, tbl[v].vjr ? jump_target : 32'd0, count},
                {tbl[v].wbv, tbl[v].wbv ? {tbl[v].wbr, tbl[v].wbd} : 37'd0,
                 tbl[v].vb, tbl[v].bo, tbl[v].vjr, tbl[v].jt, tbl[v].cnt});
            tick();
        end

        // Fill to 16, overflow attempt, drain one, wrap the tag.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            idle(); alloc_valid = 1; alloc_dest = 5'(i + 1);
            #1; tick();
        end
        idle(); alloc_valid = 1; alloc_dest = 5'd20;
        #1;
        chk("full_flags", {full, alloc_ready, alloc_tag, count},
            {1'b1, 1'b0, 4'd0, 5'd16});
        tick();
        idle(); cmpl_valid = 1; cmpl_tag = 0; cmpl_value = 32'h77;
        #1;
        chk("ovf_ignored", {alloc_tag, count}, {4'd0, 5'd16});
        tick();
        idle();
        #1;
        chk("full_commit", {wb_valid, wb_reg, wb_data},
            {1'b1, 5'd1, 32'h77});
        tick();
        idle(); alloc_valid = 1; alloc_dest = 5'd21;
        #1;
        chk("ready_again", {alloc_ready, alloc_tag, count},
            {1'b1, 4'd0, 5'd15});
        tick();
        #1;
        chk("wrap_tag", {full, alloc_tag}, {1'b1, 4'd1});
        tick();

        // Alloc + commit at count 5, then reset over flush/alloc/cmpl.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle(); alloc_valid = 1; alloc_dest = 5'(i + 1);
            if (i == 4) begin
                cmpl_valid = 1; cmpl_tag = 0; cmpl_value = 32'h5;
            end
            #1; tick();
        end
        idle(); alloc_valid = 1; alloc_dest = 5'd9;
        #1;
        chk("ac_pre", {wb_valid, count}, {1'b1, 5'd5});
        tick();
        #1;
        chk("ac_post", count, 5'd5);
        tick();
        rst_n = 0; alloc_valid = 1; flush = 1;
        cmpl_valid = 1; cmpl_tag = 1;
        #1; tick();
        idle();
        #1;
        chk("midrst", {empty, count, alloc_tag, wb_valid, valid_branch,
            valid_jump_reg}, {1'b1, 5'd0, 4'd0, 3'd0});
        tick();

        // Random traffic against the reference model.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int k;
            idle();
            rst_n = ($urandom_range(0, 299) != 0);
            alloc_valid = ($urandom_range(0, 9) < 6);
            k = $urandom_range(0, 9);
            alloc_is_branch = (k < 2);
            alloc_is_jr = (k == 2);
            alloc_is_store = (k == 3 || k == 4);
            alloc_dest = 5'($urandom_range(0, 31));
            cmpl_valid = ($urandom_range(0, 9) < 6);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                cmpl_tag = RDB'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                cmpl_tag = RDB'($urandom_range(0, ROB_DEPTH - 1));
            cmpl_value = $urandom;
            cmpl_taken = $urandom_range(0, 1);
            cmpl_target = $urandom;
            commit_stall = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 39) == 0);
            #1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
